// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings and widths for the I2C requester arbiter
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_CPL     = 3'd4
    } state_t;

    localparam int NB_W        = 6;
    localparam int DEV_W       = 7;
    localparam int PTR_W       = 8;
    localparam int DAT_W       = 8;
    localparam int TMR_W       = 16;
    localparam int TIMEOUT_DEF = 65535;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-one finder
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    // Walk offsets from the far end so the closest set bit to i_ptr is the last write.
    always_comb begin
        logic [IW-1:0] w_cand;
        w_cand  = '0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin arbiter sharing one I2C master between requesters
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         req_rw,
    input  logic [NB_W*NREQ-1:0]    req_nbyte,
    input  logic [DEV_W*NREQ-1:0]   req_dev,
    input  logic [PTR_W*NREQ-1:0]   req_ptr,
    input  logic [DAT_W*NREQ-1:0]   req_dwr,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         cpl,
    output logic [NREQ-1:0]         err,
    output logic [DAT_W-1:0]        rd_data,
    input  logic                    m_ready,
    input  logic                    m_done,
    input  logic                    m_ack_e,
    input  logic [DAT_W-1:0]        m_drd,
    output logic                    m_go,
    output logic                    m_rw,
    output logic [NB_W-1:0]         m_nbyte,
    output logic [DEV_W-1:0]        m_dev,
    output logic [PTR_W-1:0]        m_ptr,
    output logic [DAT_W-1:0]        m_dwr,
    output logic                    m_abort
);

    localparam int IW = $clog2(NREQ);
    localparam logic [TMR_W-1:0] TMO = TMR_W'(TIMEOUT);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_owner;
    logic [TMR_W-1:0]    r_timer;
    logic [NREQ-1:0]     r_err;
    logic                r_rw;
    logic [NB_W-1:0]     r_nbyte;
    logic [DEV_W-1:0]    r_dev;
    logic [PTR_W-1:0]    r_ptr;

    logic                w_pick_valid;
    logic [IW-1:0]       w_pick_idx;
    logic                w_launch;
    logic                w_waiting;
    logic                w_timeout;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_launch  = (r_state == ST_IDLE) && w_pick_valid && m_ready;
    assign w_waiting = (r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI);
    assign w_timeout = w_waiting && (r_timer == TMO);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout is tested ahead of the done edge so a coincident done still aborts.
    always_comb begin
        w_state_nxt = r_state;
        m_go        = 1'b0;
        m_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                m_go        = 1'b1;
                w_state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (w_timeout) begin
                    m_abort     = 1'b1;
                    w_state_nxt = ST_CPL;
                end else if (!m_done) begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (w_timeout) begin
                    m_abort     = 1'b1;
                    w_state_nxt = ST_CPL;
                end else if (m_done) begin
                    w_state_nxt = ST_CPL;
                end
            end
            ST_CPL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_timer  <= '0;
            r_err    <= '0;
            r_rw     <= 1'b0;
            r_nbyte  <= '0;
            r_dev    <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_owner             <= w_pick_idx;
                        r_rw                <= req_rw[w_pick_idx];
                        r_nbyte             <= req_nbyte[int'(w_pick_idx)*NB_W +: NB_W];
                        r_dev               <= req_dev[int'(w_pick_idx)*DEV_W +: DEV_W];
                        r_ptr               <= req_ptr[int'(w_pick_idx)*PTR_W +: PTR_W];
                        r_err[w_pick_idx]   <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_timer <= '0;
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    if (w_timeout) begin
                        r_err[r_owner] <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                        if ((r_state == ST_WAIT_HI) && m_done) begin
                            r_err[r_owner] <= m_ack_e;
                        end
                    end
                end
                ST_CPL: begin
                    r_rr_ptr <= (int'(r_owner) == NREQ - 1) ? '0 : r_owner + IW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        gnt = '0;
        cpl = '0;
        if (r_state != ST_IDLE) begin
            gnt[r_owner] = 1'b1;
        end
        if (r_state == ST_CPL) begin
            cpl[r_owner] = 1'b1;
        end
    end

    assign err     = r_err;
    assign m_rw    = r_rw;
    assign m_nbyte = r_nbyte;
    assign m_dev   = r_dev;
    assign m_ptr   = r_ptr;
    assign m_dwr   = (r_state != ST_IDLE) ? req_dwr[int'(r_owner)*DAT_W +: DAT_W] : '0;
    assign rd_data = (r_state != ST_IDLE) ? m_drd : '0;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - self-checking bench for i2c_arbiter with a transaction-level model
module tb_i2c_arbiter;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     req_rw = '0;
    logic [6*N-1:0]   req_nbyte = '0;
    logic [7*N-1:0]   req_dev = '0;
    logic [8*N-1:0]   req_ptr = '0;
    logic [8*N-1:0]   req_dwr = '0;
    logic [N-1:0]     gnt, cpl, err;
    logic [7:0]       rd_data;
    logic             m_ready;
    logic             m_done = 1'b1;
    logic             m_ack_e = 1'b0;
    logic [7:0]       m_drd = 8'h00;
    logic             m_go, m_rw, m_abort;
    logic [5:0]       m_nbyte;
    logic [6:0]       m_dev;
    logic [7:0]       m_ptr, m_dwr;

    always #5 clk = ~clk;

    i2c_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_nbyte(req_nbyte),
        .req_dev(req_dev), .req_ptr(req_ptr), .req_dwr(req_dwr), .gnt(gnt), .cpl(cpl),
        .err(err), .rd_data(rd_data), .m_ready(m_ready), .m_done(m_done), .m_ack_e(m_ack_e),
        .m_drd(m_drd), .m_go(m_go), .m_rw(m_rw), .m_nbyte(m_nbyte), .m_dev(m_dev),
        .m_ptr(m_ptr), .m_dwr(m_dwr), .m_abort(m_abort)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Master engine model: drops done drop_dly cycles after go, raises it hi_dly later.
    bit ready_en = 1'b1;
    bit hang = 1'b0;
    bit ack_val = 1'b0;
    int drop_dly = 3;
    int hi_dly = 40;
    bit ms_busy = 1'b0;
    int ms_c = 0;
    int done_rise_cyc = -1;
    bit go_l = 1'b0;
    bit ab_l = 1'b0;

    assign m_ready = ready_en && !ms_busy;

    always @(negedge clk) begin
        go_l = m_go;
        ab_l = m_abort;
    end

    always @(posedge reset) begin
        ms_busy = 1'b0;
        m_done  = 1'b1;
        m_ack_e = 1'b0;
        go_l    = 1'b0;
        ab_l    = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        m_drd = 8'(cyc * 7 + 3);
        if (!reset) begin
            if (ab_l) begin
                ms_busy = 1'b0;
                m_done  = 1'b1;
            end else begin
                if (go_l) begin
                    ms_busy = 1'b1;
                    ms_c    = 0;
                    m_ack_e = 1'b0;
                end
                if (ms_busy) begin
                    ms_c++;
                    if (ms_c == drop_dly) m_done = 1'b0;
                    if (ms_c == drop_dly + hi_dly && !hang) begin
                        m_done        = 1'b1;
                        m_ack_e       = ack_val;
                        ms_busy       = 1'b0;
                        done_rise_cyc = cyc;
                    end
                end
            end
        end
    end

    // Transaction-level model: mt counts cycles since the grant edge.
    bit         mbusy = 1'b0;
    bit         msaw = 1'b0;
    bit         mfin = 1'b0;
    int         mo = 0;
    int         mt = 0;
    int         mrr = 0;
    bit [N-1:0] merr = '0;
    logic       mrw = 1'b0;
    logic [5:0] mnb = '0;
    logic [6:0] mdev = '0;
    logic [7:0] mptr = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mbusy = 0; msaw = 0; mfin = 0; mo = 0; mt = 0; mrr = 0; merr = '0;
            mrw = 0; mnb = '0; mdev = '0; mptr = '0;
        end else if (!mbusy) begin
            if (|req && m_ready) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(mrr + k) % N]) mo = (mrr + k) % N;
                mbusy = 1; mt = 0; msaw = 0; mfin = 0; merr[mo] = 1'b0;
                mrw = req_rw[mo]; mnb = req_nbyte[mo*6 +: 6];
                mdev = req_dev[mo*7 +: 7]; mptr = req_ptr[mo*8 +: 8];
            end
        end else if (mfin) begin
            mbusy = 0;
            mrr = (mo + 1) % N;
        end else if (mt == 0) begin
            mt = 1;
        end else if (mt - 1 == TMO) begin
            merr[mo] = 1'b1;
            mfin = 1;
        end else begin
            if (!msaw) begin
                if (!m_done) msaw = 1;
            end else if (m_done) begin
                merr[mo] = m_ack_e;
                mfin = 1;
            end
            mt++;
        end
    end

    int n_go = 0, n_cpl = 0, n_abort = 0;
    int go_cyc = 0, cpl_cyc = 0, abort_cyc = 0;
    int q_order[$];
    int q_go[$];
    logic [6:0] go_dev;
    logic [7:0] go_ptr;
    logic [5:0] go_nb;
    logic       go_rw;
    logic [N-1:0] go_err, cpl_vec, cpl_err;
    event ev_smp;

    always @(negedge clk) begin : cmp
        logic [N-1:0] eg, ec;
        eg = '0;
        ec = '0;
        if (mbusy) eg[mo] = 1'b1;
        if (mbusy && mfin) ec[mo] = 1'b1;
        chk("gnt", gnt, eg);
        chk("cpl", cpl, ec);
        chk("err", err, merr);
        chk("m_go", m_go, mbusy && !mfin && mt == 0);
        chk("m_abort", m_abort, mbusy && !mfin && mt >= 1 && (mt - 1) == TMO);
        chk("m_rw", m_rw, mrw);
        chk("m_nbyte", m_nbyte, mnb);
        chk("m_dev", m_dev, mdev);
        chk("m_ptr", m_ptr, mptr);
        chk("m_dwr", m_dwr, mbusy ? req_dwr[mo*8 +: 8] : 8'h00);
        chk("rd_data", rd_data, mbusy ? m_drd : 8'h00);
        chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
        if (m_go) begin
            n_go++;
            go_cyc = cyc;
            q_go.push_back(cyc);
            for (int i = 0; i < N; i++) if (gnt[i]) q_order.push_back(i);
            go_dev = m_dev; go_ptr = m_ptr; go_nb = m_nbyte; go_rw = m_rw; go_err = err;
        end
        if (|cpl) begin
            n_cpl++;
            cpl_cyc = cyc;
            cpl_vec = cpl;
            cpl_err = err;
        end
        if (m_abort) begin
            n_abort++;
            abort_cyc = cyc;
        end
        -> ev_smp;
    end

    task automatic wait_cpl(input int tgt, input int lim, input string nm);
        int k = 0;
        while (n_cpl < tgt && k < lim) begin
            @(ev_smp);
            k++;
        end
        chk({nm, "_cpl_seen"}, 32'(n_cpl >= tgt), 1);
    endtask

    task automatic wait_go(input int tgt, input int lim, input string nm);
        int k = 0;
        while (n_go < tgt && k < lim) begin
            @(ev_smp);
            k++;
        end
        chk({nm, "_go_seen"}, 32'(n_go >= tgt), 1);
    endtask

    task automatic set_desc(input int i, input bit rw, input logic [5:0] nb, input logic [6:0] dev,
                            input logic [7:0] ptr, input logic [7:0] dwr);
        req_rw[i] = rw;
        req_nbyte[i*6 +: 6] = nb;
        req_dev[i*7 +: 7] = dev;
        req_ptr[i*8 +: 8] = ptr;
        req_dwr[i*8 +: 8] = dwr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_go, base_cpl, base_ab, r;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};

        // Reset values, then all four requesters held from reset.
        for (int i = 0; i < N; i++) set_desc(i, i[0], 6'(i + 1), 7'(8'h20 + i), 8'(8'h40 + i), 8'(8'h80 + i));
        req = 4'b1111;
        drop_dly = 1;
        hi_dly = 2;
        @(ev_smp);
        chk("rst_gnt", gnt, 0);
        chk("rst_cpl", cpl, 0);
        chk("rst_err", err, 0);
        chk("rst_go", m_go, 0);
        chk("rst_dev", m_dev, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_cpl(5, 200, "t2");
        req = '0;
        chk("t2_ngo", q_order.size(), 5);
        for (int k = 0; k < 5; k++) if (k < q_order.size()) chk($sformatf("t2_order%0d", k), q_order[k], exp_ord[k]);
        for (int k = 0; k < 4; k++) if (k + 1 < q_go.size()) chk($sformatf("t2_gap%0d", k), q_go[k+1] - q_go[k], 6);

        // Single read on requester 0.
        repeat (3) @(ev_smp);
        drop_dly = 3;
        hi_dly = 40;
        set_desc(0, 1'b1, 6'd2, 7'h48, 8'h10, 8'h00);
        base_go = n_go;
        base_cpl = n_cpl;
        req = 4'b0001;
        wait_cpl(base_cpl + 1, 200, "t1");
        req = '0;
        chk("t1_ngo", n_go - base_go, 1);
        chk("t1_dev", go_dev, 8'h48);
        chk("t1_ptr", go_ptr, 8'h10);
        chk("t1_rw", go_rw, 1);
        chk("t1_nb", go_nb, 2);
        chk("t1_cpl_lat", cpl_cyc - done_rise_cyc, 1);
        chk("t1_cpl_vec", cpl_vec, 4'b0001);
        chk("t1_err", cpl_err[0], 0);

        // Write on requester 2 that NACKs; descriptor frozen, dwr live.
        repeat (3) @(ev_smp);
        drop_dly = 2;
        hi_dly = 6;
        ack_val = 1'b1;
        set_desc(2, 1'b0, 6'd3, 7'h50, 8'h22, 8'hA5);
        base_go = n_go;
        base_cpl = n_cpl;
        req = 4'b0100;
        wait_go(base_go + 1, 20, "t3");
        repeat (2) @(ev_smp);
        req_dev[2*7 +: 7] = 7'h11;
        req_dwr[2*8 +: 8] = 8'h5A;
        wait_cpl(base_cpl + 1, 100, "t3");
        req = '0;
        chk("t3_dev", go_dev, 8'h50);
        chk("t3_cpl_vec", cpl_vec, 4'b0100);
        chk("t3_err", cpl_err[2], 1);
        repeat (4) @(ev_smp);
        chk("t3_err_held", err[2], 1);
        ack_val = 1'b0;
        base_cpl = n_cpl;
        req = 4'b0100;
        wait_go(base_go + 2, 20, "t3b");
        chk("t3_err_clr", go_err[2], 0);
        wait_cpl(base_cpl + 1, 100, "t3b");
        req = '0;
        chk("t3b_err", cpl_err[2], 0);

        // Watchdog abort on requester 1.
        repeat (3) @(ev_smp);
        hang = 1'b1;
        base_cpl = n_cpl;
        base_ab = n_abort;
        req = 4'b0010;
        wait_cpl(base_cpl + 1, 300, "t4");
        req = '0;
        chk("t4_nabort", n_abort - base_ab, 1);
        chk("t4_abort_lat", abort_cyc - go_cyc, TMO + 1);
        chk("t4_cpl_vec", cpl_vec, 4'b0010);
        chk("t4_err", cpl_err[1], 1);
        hang = 1'b0;
        repeat (3) @(ev_smp);
        chk("t4_idle", gnt, 0);

        // Master not ready holds off requester 3.
        ready_en = 1'b0;
        base_go = n_go;
        base_cpl = n_cpl;
        req = 4'b1000;
        repeat (10) @(ev_smp);
        chk("t5_nogo", n_go - base_go, 0);
        chk("t5_nognt", gnt, 0);
        ready_en = 1'b1;
        r = cyc;
        @(ev_smp);
        chk("t5_gnt", gnt, 4'b1000);
        chk("t5_gnt_cyc", cyc - r, 1);
        wait_cpl(base_cpl + 1, 100, "t5");
        req = '0;

        // Reset during WAIT_HI: rr pointer returns to 0.
        repeat (3) @(ev_smp);
        drop_dly = 1;
        hi_dly = 2;
        base_cpl = n_cpl;
        req = 4'b0010;
        wait_cpl(base_cpl + 1, 100, "t6a");
        req = '0;
        repeat (3) @(ev_smp);
        hi_dly = 40;
        base_go = n_go;
        req = 4'b0101;
        wait_go(base_go + 1, 20, "t6");
        chk("t6_owner", q_order[$], 2);
        r = 0;
        while (m_done && r < 20) begin
            @(ev_smp);
            r++;
        end
        chk("t6_done_low", m_done, 0);
        repeat (5) @(ev_smp);
        base_cpl = n_cpl;
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_cpl", cpl, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_dwr", m_dwr, 0);
        chk("t6_rst_rd", rd_data, 0);
        chk("t6_rst_dev", m_dev, 0);
        repeat (3) @(ev_smp);
        chk("t6_no_cpl", n_cpl - base_cpl, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_go(base_go + 2, 20, "t6b");
        chk("t6_rr_reset", q_order[$], 0);
        wait_cpl(base_cpl + 1, 100, "t6b");
        req = '0;
        repeat (3) @(ev_smp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
